// File: rtl/ct_operand_loader_if.sv
// Stream-in / frame-out bundle between the operand source, the loader and the CT block.
interface ct_operand_loader_if #(
    parameter int DATA_W = 4,
    parameter int OP_W   = 5,
    parameter int RES_W  = 9,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [OP_W-1:0]   in_opcode;
    logic              out_valid;
    logic              out_ready;
    logic [OP_W-1:0]   opcode;
    logic [DATA_W-1:0] in_n0;
    logic [DATA_W-1:0] in_n1;
    logic [DATA_W-1:0] in_n2;
    logic [DATA_W-1:0] in_n3;
    logic [DATA_W-1:0] in_n4;
    logic [DATA_W-1:0] in_n5;
    logic [RES_W-1:0]  ct_out_n;
    logic [RES_W-1:0]  res_n;
    logic              res_valid;
    logic [CNT_W-1:0]  frame_cnt;

    modport master (
        output in_valid, in_data, in_opcode, out_ready, ct_out_n,
        input  in_ready, out_valid, opcode, in_n0, in_n1, in_n2, in_n3, in_n4, in_n5,
               res_n, res_valid, frame_cnt
    );

    modport slave (
        input  in_valid, in_data, in_opcode, out_ready, ct_out_n,
        output in_ready, out_valid, opcode, in_n0, in_n1, in_n2, in_n3, in_n4, in_n5,
               res_n, res_valid, frame_cnt
    );
endinterface

// File: rtl/ct_operand_loader.sv
// Collects one opcode plus six operand beats into a stable frame for CT and captures its result.
// Optional synchronous abort input is enabled by defining CT_LOADER_ABORT_EN.
module ct_operand_loader #(
    parameter int NUM_OPND = 6,
    parameter int DATA_W   = 4,
    parameter int OP_W     = 5,
    parameter int RES_W    = 9,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rst_n,
`ifdef CT_LOADER_ABORT_EN
    input  logic abort,
`endif
    ct_operand_loader_if.slave bus
);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    localparam logic [2:0] LAST_BEAT = 3'(NUM_OPND - 1);

    state_t            state;
    logic [2:0]        cnt;
    logic [OP_W-1:0]   opcode_q;
    logic [DATA_W-1:0] opnd_q [NUM_OPND];
    logic              out_valid_q;
    logic              res_valid_q;
    logic [RES_W-1:0]  res_q;
    logic [CNT_W-1:0]  frame_cnt_q;
    logic              abort_hit;

`ifdef CT_LOADER_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            opcode_q    <= '0;
            out_valid_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_q       <= '0;
            frame_cnt_q <= '0;
            for (int i = 0; i < NUM_OPND; i++) begin
                opnd_q[i] <= '0;
            end
        end else begin
            res_valid_q <= 1'b0;
            // Abort wins over any beat or consume happening on the same edge.
            if (abort_hit) begin
                state       <= IDLE;
                cnt         <= '0;
                out_valid_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.in_valid) begin
                            opcode_q  <= bus.in_opcode;
                            opnd_q[0] <= bus.in_data;
                            cnt       <= 3'd1;
                            state     <= LOAD;
                        end
                    end
                    LOAD: begin
                        if (bus.in_valid) begin
                            for (int i = 1; i < NUM_OPND; i++) begin
                                if (cnt == 3'(i)) begin
                                    opnd_q[i] <= bus.in_data;
                                end
                            end
                            if (cnt == LAST_BEAT) begin
                                cnt         <= '0;
                                out_valid_q <= 1'b1;
                                state       <= HOLD;
                            end else begin
                                cnt <= cnt + 3'd1;
                            end
                        end
                    end
                    HOLD: begin
                        // CT is combinational, so its output already reflects the held frame.
                        if (bus.out_ready) begin
                            res_q       <= bus.ct_out_n;
                            res_valid_q <= 1'b1;
                            frame_cnt_q <= frame_cnt_q + 1'b1;
                            out_valid_q <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.in_ready  = (state != HOLD);
    assign bus.out_valid = out_valid_q;
    assign bus.opcode    = opcode_q;
    assign bus.in_n0     = opnd_q[0];
    assign bus.in_n1     = opnd_q[1];
    assign bus.in_n2     = opnd_q[2];
    assign bus.in_n3     = opnd_q[3];
    assign bus.in_n4     = opnd_q[4];
    assign bus.in_n5     = opnd_q[5];
    assign bus.res_n     = res_q;
    assign bus.res_valid = res_valid_q;
    assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_ct_operand_loader.sv
// Bench for ct_operand_loader: directed vector table, corner sequences and random run vs a queue model.
// Define CT_LOADER_ABORT_EN to also exercise the abort input.
module tb_ct_operand_loader;

    logic clk;
    logic rst_n;
`ifdef CT_LOADER_ABORT_EN
    logic abort;
`endif

    ct_operand_loader_if bus ();

    ct_operand_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef CT_LOADER_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the CT block: operand sum with the opcode's upper bits folded in.
    function automatic logic [8:0] ctModel(input logic [4:0] opc, input logic [23:0] ops);
        logic [8:0] sum;
        sum = '0;
        for (int i = 0; i < 6; i++) sum = sum + 9'(ops[4*i +: 4]);
        return sum ^ {opc[4:2], 6'b0};
    endfunction

    assign bus.ct_out_n = ctModel(bus.opcode,
        {bus.in_n5, bus.in_n4, bus.in_n3, bus.in_n2, bus.in_n1, bus.in_n0});

    typedef struct {
        logic        in_valid;
        logic [3:0]  data;
        logic [4:0]  opc;
        logic        out_ready;
        logic        abort_i;
        logic        exp_in_ready;
        logic        exp_out_valid;
        logic        exp_res_valid;
        logic [8:0]  exp_res;
        logic [7:0]  exp_cnt;
        logic        chk_frame;
        logic [4:0]  exp_opc;
        logic [23:0] exp_ops;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;
    vec_t vecs[$];

    function automatic vec_t mkVec(input logic iv, input logic [3:0] d, input logic [4:0] opc,
                                   input logic ordy, input logic eir, input logic eov,
                                   input logic erv, input logic [8:0] eres, input logic [7:0] ecnt,
                                   input logic chk, input logic [4:0] eopc, input logic [23:0] eops);
        vec_t v;
        v = '{iv, d, opc, ordy, 1'b0, eir, eov, erv, eres, ecnt, chk, eopc, eops};
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] dutOps();
        return {bus.in_n5, bus.in_n4, bus.in_n3, bus.in_n2, bus.in_n1, bus.in_n0};
    endfunction

    task automatic applyStimulus(input vec_t v);
        bus.in_valid  = v.in_valid;
        bus.in_data   = v.data;
        bus.in_opcode = v.opc;
        bus.out_ready = v.out_ready;
`ifdef CT_LOADER_ABORT_EN
        abort = v.abort_i;
`endif
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        checkVal($sformatf("in_ready[%0d]", idx), 32'(bus.in_ready), 32'(v.exp_in_ready));
        checkVal($sformatf("out_valid[%0d]", idx), 32'(bus.out_valid), 32'(v.exp_out_valid));
        checkVal($sformatf("res_valid[%0d]", idx), 32'(bus.res_valid), 32'(v.exp_res_valid));
        checkVal($sformatf("res_n[%0d]", idx), 32'(bus.res_n), 32'(v.exp_res));
        checkVal($sformatf("frame_cnt[%0d]", idx), 32'(bus.frame_cnt), 32'(v.exp_cnt));
        if (v.chk_frame) begin
            checkVal($sformatf("opcode[%0d]", idx), 32'(bus.opcode), 32'(v.exp_opc));
            checkVal($sformatf("operands[%0d]", idx), 32'(dutOps()), 32'(v.exp_ops));
        end
    endtask

    task automatic idleInputs();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_opcode = '0;
        bus.out_ready = 1'b0;
`ifdef CT_LOADER_ABORT_EN
        abort = 1'b0;
`endif
    endtask

    task automatic doReset();
        idleInputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic driveBeat(input logic [3:0] d, input logic [4:0] opc);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_opcode = opc;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Six back-to-back beats, check the presented frame, then consume it and check the result.
    task automatic sendFrame(input logic [4:0] opc, input logic [23:0] ops);
        bit seen;
        for (int i = 0; i < 6; i++) driveBeat(ops[4*i +: 4], (i == 0) ? opc : ~opc);
        checkVal("frame_out_valid", 32'(bus.out_valid), 32'd1);
        checkVal("frame_opcode", 32'(bus.opcode), 32'(opc));
        checkVal("frame_ops", 32'(dutOps()), 32'(ops));
        bus.out_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.res_valid) seen = 1'b1;
        end
        checkVal("frame_res_seen", 32'(seen), 32'd1);
        checkVal("frame_res_n", 32'(bus.res_n), 32'(ctModel(opc, ops)));
        bus.out_ready = 1'b0;
    endtask

    // Reference model state: beats of the frame under assembly, plus what CT currently sees.
    logic [3:0]  beat_q[$];
    logic [4:0]  m_opc;
    logic [23:0] m_ops;
    logic        m_held;
    logic [8:0]  m_res;
    logic        m_res_valid;
    logic [7:0]  m_cnt;

    initial begin
        rst_n = 1'b1;
        idleInputs();
        @(negedge clk);
        doReset();

        // Reset state
        checkVal("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkVal("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkVal("rst_ops", 32'(dutOps()), 32'd0);
        checkVal("rst_opcode", 32'(bus.opcode), 32'd0);

        // Back-to-back frame, long HOLD, consume with in_valid still high
        vecs.push_back(mkVec(1, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(1, 2, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(1, 3, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(1, 4, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(1, 5, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(1, 6, 3, 0, 0, 1, 0, 0, 0, 1, 3, 24'h654321));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mkVec(1, 9, 31, 0, 0, 1, 0, 0, 0, 1, 3, 24'h654321));
        vecs.push_back(mkVec(1, 9, 31, 1, 1, 0, 1, 21, 1, 1, 3, 24'h654321));
        vecs.push_back(mkVec(0, 0, 0, 0, 1, 0, 0, 21, 1, 1, 3, 24'h654321));
        // Gapped beats, opcode changes ignored after beat 1, early out_ready
        vecs.push_back(mkVec(1, 7, 2, 0, 1, 0, 0, 21, 1, 0, 0, 0));
        vecs.push_back(mkVec(0, 15, 20, 0, 1, 0, 0, 21, 1, 0, 0, 0));
        vecs.push_back(mkVec(0, 14, 21, 0, 1, 0, 0, 21, 1, 0, 0, 0));
        vecs.push_back(mkVec(1, 8, 9, 0, 1, 0, 0, 21, 1, 0, 0, 0));
        vecs.push_back(mkVec(0, 1, 1, 0, 1, 0, 0, 21, 1, 0, 0, 0));
        vecs.push_back(mkVec(1, 9, 10, 0, 1, 0, 0, 21, 1, 0, 0, 0));
        vecs.push_back(mkVec(1, 10, 11, 0, 1, 0, 0, 21, 1, 0, 0, 0));
        vecs.push_back(mkVec(0, 2, 2, 0, 1, 0, 0, 21, 1, 0, 0, 0));
        vecs.push_back(mkVec(1, 11, 12, 0, 1, 0, 0, 21, 1, 0, 0, 0));
        vecs.push_back(mkVec(0, 3, 4, 1, 1, 0, 0, 21, 1, 0, 0, 0));
        vecs.push_back(mkVec(1, 12, 13, 1, 0, 1, 0, 21, 1, 1, 2, 24'hCBA987));
        vecs.push_back(mkVec(0, 0, 0, 1, 1, 0, 1, 57, 2, 1, 2, 24'hCBA987));
        vecs.push_back(mkVec(0, 0, 0, 0, 1, 0, 0, 57, 2, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            @(negedge clk);
            checkOutput(vecs[i], i);
        end
        idleInputs();

        // Frame counter wrap
        doReset();
        for (int f = 0; f < 256; f++) sendFrame(5'($urandom), 24'($urandom));
        checkVal("wrap_256", 32'(bus.frame_cnt), 32'd0);
        sendFrame(5'd17, 24'h0F0F0F);
        checkVal("wrap_257", 32'(bus.frame_cnt), 32'd1);

        // Asynchronous reset in the middle of a frame
        driveBeat(4'd1, 5'd7);
        driveBeat(4'd2, 5'd7);
        driveBeat(4'd3, 5'd7);
        #2 rst_n = 1'b0;
        #1;
        checkVal("arst_ops", 32'(dutOps()), 32'd0);
        checkVal("arst_opcode", 32'(bus.opcode), 32'd0);
        checkVal("arst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        checkVal("arst_res_n", 32'(bus.res_n), 32'd0);
        checkVal("arst_out_valid", 32'(bus.out_valid), 32'd0);
        checkVal("arst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        sendFrame(5'd6, 24'h987654);
        checkVal("arst_next_cnt", 32'(bus.frame_cnt), 32'd1);

`ifdef CT_LOADER_ABORT_EN
        // Abort coinciding with the sixth beat
        for (int i = 0; i < 5; i++) driveBeat(4'(i + 1), 5'd9);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'd6;
        abort        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort        = 1'b0;
        bus.in_valid = 1'b0;
        checkVal("abort_out_valid", 32'(bus.out_valid), 32'd0);
        checkVal("abort_in_ready", 32'(bus.in_ready), 32'd1);
        checkVal("abort_frame_cnt", 32'(bus.frame_cnt), 32'd1);
        checkVal("abort_res_valid", 32'(bus.res_valid), 32'd0);
        sendFrame(5'd12, 24'h3C5A69);
        checkVal("abort_next_cnt", 32'(bus.frame_cnt), 32'd2);
`endif

        // Random traffic against the queue model
        doReset();
        beat_q.delete();
        m_opc = '0; m_ops = '0; m_held = 1'b0; m_res = '0; m_res_valid = 1'b0; m_cnt = '0;
        for (int c = 0; c < 800; c++) begin
            logic iv, ordy, ab;
            logic [3:0] d;
            logic [4:0] opc;
            checkVal("rnd_in_ready", 32'(bus.in_ready), 32'(!m_held));
            checkVal("rnd_out_valid", 32'(bus.out_valid), 32'(m_held));
            checkVal("rnd_res_valid", 32'(bus.res_valid), 32'(m_res_valid));
            checkVal("rnd_res_n", 32'(bus.res_n), 32'(m_res));
            checkVal("rnd_frame_cnt", 32'(bus.frame_cnt), 32'(m_cnt));
            checkVal("rnd_opcode", 32'(bus.opcode), 32'(m_opc));
            checkVal("rnd_ops", 32'(dutOps()), 32'(m_ops));
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) == 0);
            d    = 4'($urandom);
            opc  = 5'($urandom);
            ab   = 1'b0;
            bus.in_valid  = iv;
            bus.in_data   = d;
            bus.in_opcode = opc;
            bus.out_ready = ordy;
`ifdef CT_LOADER_ABORT_EN
            ab    = ($urandom_range(0, 15) == 0);
            abort = ab;
`endif
            @(posedge clk);
            m_res_valid = 1'b0;
            if (ab) begin
                beat_q.delete();
                m_held = 1'b0;
            end else if (m_held) begin
                if (ordy) begin
                    m_res       = ctModel(m_opc, m_ops);
                    m_res_valid = 1'b1;
                    m_cnt       = m_cnt + 8'd1;
                    m_held      = 1'b0;
                end
            end else if (iv) begin
                if (beat_q.size() == 0) m_opc = opc;
                m_ops[4*beat_q.size() +: 4] = d;
                beat_q.push_back(d);
                if (beat_q.size() == 6) begin
                    m_held = 1'b1;
                    beat_q.delete();
                end
            end
            @(negedge clk);
        end
        idleInputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
